// File: rtl/addr_sweep_gen.sv
// addr_sweep_gen: programmable address sequencer feeding the address encoder.
// On an accepted start it emits base + k*stride (mod 2^AW) for k = 0..count-1,
// one address per non-stalled cycle, then pulses done and returns to idle.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - sweep request, sampled only in IDLE
//   base, stride - first address and increment, latched on start acceptance
//   count        - number of addresses (0..2^AW), latched on start acceptance
//   stall        - hold the current address (not consumed this cycle)
//   addr         - registered address to the encoder
//   addr_valid   - addr holds a sweep address
//   busy         - high while a sweep is running
//   done         - one-cycle pulse after the last address is consumed
module addr_sweep_gen #(
    parameter int unsigned AW = 12,
    parameter int unsigned CW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] stride,
    input  logic [CW-1:0] count,
    input  logic          stall,
    output logic [AW-1:0] addr,
    output logic          addr_valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] stride_q, stride_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic          addr_valid_q, addr_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          consume_c;

    // The presented address is taken by the encoder when valid and not stalled.
    assign consume_c = addr_valid_q && !stall;

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        stride_d     = stride_q;
        remaining_d  = remaining_q;
        addr_valid_d = addr_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                addr_valid_d = 1'b0;
                busy_d       = 1'b0;
                if (start) begin
                    if (count != CW'(0)) begin
                        state_d      = S_RUN;
                        addr_d       = base;
                        stride_d     = stride;
                        remaining_d  = count;
                        addr_valid_d = 1'b1;
                        busy_d       = 1'b1;
                    end else begin
                        // Empty sweep: report completion without emitting anything.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (consume_c) begin
                    remaining_d = remaining_q - CW'(1);
                    if (remaining_q > CW'(1)) begin
                        // AW-bit add; carry-out dropped so the address wraps silently.
                        addr_d = addr_q + stride_q;
                    end else begin
                        // Last address consumed: addr keeps showing it.
                        state_d      = S_DONE;
                        addr_valid_d = 1'b0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d      = S_IDLE;
                addr_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
            default: begin
                state_d      = S_IDLE;
                addr_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            stride_q     <= '0;
            remaining_q  <= '0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            stride_q     <= stride_d;
            remaining_q  <= remaining_d;
            addr_valid_q <= addr_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign addr       = addr_q;
    assign addr_valid = addr_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_addr_sweep_gen.sv
// Testbench for addr_sweep_gen: table of sweep configurations checked against a
// scoreboard of expected addresses, plus hand sequences for reset mid-sweep and
// back-to-back starts.
module tb_addr_sweep_gen;

    localparam int unsigned AW = 12;
    localparam int unsigned CW = 13;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    logic [CW-1:0] count;
    logic          stall;
    logic [AW-1:0] addr;
    logic          addr_valid;
    logic          busy;
    logic          done;

    addr_sweep_gen #(.AW(AW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base       (base),
        .stride     (stride),
        .count      (count),
        .stall      (stall),
        .addr       (addr),
        .addr_valid (addr_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] b;
        logic [AW-1:0] s;
        logic [CW-1:0] c;
        int            stall_at;   // scoreboard index to stall on, -1 for none
        int            stall_len;
        bit            restart;    // hold start high and scramble inputs during the sweep
        int            exp_busy;   // busy cycles == cycle index of done
        logic [AW-1:0] exp_last;
    } sweep_t;

    typedef struct {
        logic          v;
        logic [AW-1:0] a;
        logic          d;
        logic          b;
    } step_t;

    logic [AW-1:0] sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_sweep(input sweep_t v);
        int cyc, idx, stalls, busy_cyc, done_cyc;
        @(negedge clk);
        base   = v.b;
        stride = v.s;
        count  = v.c;
        start  = 1'b1;
        stall  = 1'b0;
        for (int k = 0; k < int'(v.c); k++)
            sb.push_back(AW'(int'(v.b) + k * int'(v.s)));
        @(negedge clk);
        if (!v.restart) start = 1'b0;
        cyc = 0; idx = 0; stalls = 0; busy_cyc = 0; done_cyc = -1;
        while (done_cyc < 0 && cyc < 6000) begin
            if (v.restart) begin
                base = 12'hABC; stride = 12'h111; count = 13'd9;
            end
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc = cyc;
            end else if (addr_valid) begin
                if (sb.size() == 0) begin
                    check("extra_addr", 32'(addr), 32'hFFFF_FFFF);
                    stall = 1'b0;
                end else begin
                    check("addr", 32'(addr), 32'(sb[0]));
                    if (idx == v.stall_at && stalls < v.stall_len) begin
                        stall = 1'b1;
                        stalls++;
                    end else begin
                        stall = 1'b0;
                        void'(sb.pop_front());
                        idx++;
                    end
                end
            end else begin
                stall = 1'b0;
            end
            if (done_cyc < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        stall = 1'b0;
        check("done_cycle", 32'(done_cyc), 32'(v.exp_busy));
        check("busy_cycles", 32'(busy_cyc), 32'(v.exp_busy));
        check("valid_at_done", 32'(addr_valid), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);
        if (v.c != '0) check("last_addr", 32'(addr), 32'(v.exp_last));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(addr_valid), 32'd0);
        start = 1'b0;
        sb.delete();
    endtask

    sweep_t vec[7];
    step_t  b2b[9];

    initial begin
        vec[0] = '{12'd0,    12'd1, 13'd4096, -1, 0, 1'b0, 4096, 12'd4095};
        vec[1] = '{12'd4094, 12'd3, 13'd4,    -1, 0, 1'b0, 4,    12'd7};
        vec[2] = '{12'd10,   12'd2, 13'd3,     1, 2, 1'b0, 5,    12'd14};
        vec[3] = '{12'd55,   12'd7, 13'd0,    -1, 0, 1'b0, 0,    12'd0};
        vec[4] = '{12'd4094, 12'd3, 13'd4,    -1, 0, 1'b1, 4,    12'd7};
        vec[5] = '{12'd100,  12'd0, 13'd3,    -1, 0, 1'b0, 3,    12'd100};
        vec[6] = '{12'd7,    12'd1, 13'd1,     0, 3, 1'b0, 4,    12'd7};

        b2b[0] = '{1'b1, 12'd20, 1'b0, 1'b1};
        b2b[1] = '{1'b1, 12'd21, 1'b0, 1'b1};
        b2b[2] = '{1'b0, 12'd21, 1'b1, 1'b0};
        b2b[3] = '{1'b0, 12'd21, 1'b0, 1'b0};
        b2b[4] = '{1'b1, 12'd30, 1'b0, 1'b1};
        b2b[5] = '{1'b1, 12'd31, 1'b0, 1'b1};
        b2b[6] = '{1'b1, 12'd32, 1'b0, 1'b1};
        b2b[7] = '{1'b0, 12'd32, 1'b1, 1'b0};
        b2b[8] = '{1'b0, 12'd32, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; base = '0; stride = '0; count = '0; stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_valid", 32'(addr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_sweep(vec[i]);

        // Reset in the middle of a sweep.
        @(negedge clk);
        base = 12'd90; stride = 12'd1; count = 13'd50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 60 && addr !== 12'd100; i++) @(negedge clk);
        check("pre_reset_addr", 32'(addr), 32'd100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_addr", 32'(addr), 32'd0);
        check("mid_rst_valid", 32'(addr_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        check("post_rst_idle_valid", 32'(addr_valid), 32'd0);
        check("post_rst_idle_done", 32'(done), 32'd0);
        run_sweep('{12'd5, 12'd4, 13'd3, -1, 0, 1'b0, 3, 12'd13});

        // Back-to-back: start held high, count changed while the first sweep runs.
        @(negedge clk);
        base = 12'd20; stride = 12'd1; count = 13'd2; start = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("b2b_valid", 32'(addr_valid), 32'(b2b[i].v));
            check("b2b_addr", 32'(addr), 32'(b2b[i].a));
            check("b2b_done", 32'(done), 32'(b2b[i].d));
            check("b2b_busy", 32'(busy), 32'(b2b[i].b));
            if (i == 0) begin
                base = 12'd30; count = 13'd3;
            end
            if (i == 7) start = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addr_sweep_gen.md
# addr_sweep_gen

Programmable 12-bit address sequencer that sits directly upstream of the address encoder and drives its 12-bit `in` bus. It replaces free-running testbench stimulus with a synthesizable block. On a start command it emits a sequence of `base + k*stride` (mod 4096) addresses, one per non-stalled cycle. It then pulses `done` and returns to idle.

## Interface

Parameters:
- `AW`, default 12: address width; the encoder input width.
- `CW`, default 13: count width. Must be AW+1 so that a full 4096-address sweep is expressible.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a new sweep. Sampled only in IDLE.
- `base`  in  AW: first address. Latched when start is accepted.
- `stride`  in  AW: address increment. Latched when start is accepted.
- `count`  in  CW: number of addresses to emit (0..4096). Latched when start is accepted.
- `stall`  in  1: holds the current address. The current address is not consumed this cycle.
- `addr`  out  AW: address to the encoder `in`. Registered.
- `addr_valid`  out  1: `addr` holds a sweep address. Registered.
- `busy`  out  1: high in RUN. Registered.
- `done`  out  1: one-cycle pulse after the last address is consumed. Registered.

## Operation

- States: IDLE, RUN, DONE.
- Reset (`rst`=1 at an edge), from any state, including mid-sweep:
  - Next state is IDLE.
  - `addr`=0, `addr_valid`=0, `busy`=0, `done`=0.
  - Internal `cur`, `stride_q` and `remaining` all clear to 0.
  - Reset has priority over `start` and `stall`.
- IDLE:
  - `start`=1 with `count`≠0: latch `base`, `stride` and `count`, then go to RUN.
    - `addr` = `base`, `addr_valid`=1, `busy`=1.
    - `remaining` = `count`.
  - `start`=1 with `count`=0: go to DONE directly. No address is emitted.
  - `start`=0: remain in IDLE. `addr` holds its last value and `addr_valid`=0.
- RUN:
  - A cycle is consumed when `addr_valid`=1 and `stall`=0.
  - On a consumed cycle with `remaining`>1: `addr` ← (`addr` + `stride_q`) mod 2^AW and `remaining` decrements.
  - On a consumed cycle with `remaining`=1: go to DONE. `addr_valid`=0 and `busy`=0; `addr` holds the last address.
  - `stall`=1: `addr`, `addr_valid` and `remaining` are all held.
  - `start` is ignored in RUN, and `base`, `stride` and `count` changes have no effect.
- DONE:
  - `done`=1 for exactly one cycle, then unconditionally IDLE.
  - `start` is ignored in DONE. It is accepted again from the first IDLE cycle.
- Arithmetic:
  - The address adder is AW bits wide and its carry-out is discarded, so wrap-around from 4095 to 0 is silent.
  - `stride`=0 is legal and repeats `base` `count` times.
  - `remaining` is CW bits wide and never underflows.

## Timing

- Start latency: `start` sampled at edge N gives the first `addr`/`addr_valid` after edge N.
- Throughput: one address per clock while `stall`=0. A sweep of `count` addresses with no stalls has RUN high for exactly `count` cycles.
- Stall: each stalled cycle adds exactly one cycle to the sweep, with no address skipped or duplicated beyond the held cycle.
- Completion: the last address is consumed at edge M.
  - After edge M: `addr_valid`=0, `done`=1.
  - After edge M+1: `done`=0 and the state is IDLE.
  - The earliest next accepted `start` is sampled at edge M+2.
- All outputs are registered. No combinational path exists from any input to any output.
- The downstream encoder samples `addr` every clock. `addr_valid` is informational for the encoder and checked by the bench.

## Test plan

- Full sweep: `base`=0, `stride`=1, `count`=4096, `stall`=0.
  - Required: `addr` runs 0..4095, one per cycle, over 4096 cycles.
  - `done` pulses one cycle after address 4095.
  - The encoder output matches the existing 0..4095 stimulus sequence.
- Wrap and stride: `base`=4094, `stride`=3, `count`=4.
  - Required: 4094, 1, 4, 7, then `done`; no extra address.
- Stall: `base`=10, `stride`=2, `count`=3, with `stall`=1 for two cycles while `addr`=12.
  - Required: 10, 12, 12, 12, 14; `busy` high for 5 cycles; `done` after 14.
- Zero count and ignored start:
  - `count`=0 gives a `done` pulse one cycle after `start`, with `addr_valid` never high.
  - `start` re-asserted during RUN or DONE gives an unchanged sequence.
- Reset mid-sweep: `rst`=1 while `addr`=100.
  - Required: after that edge, all outputs are 0 and the state is IDLE.
  - A new `start` with `base`=5 then emits 5 first.
- Back-to-back: `start` held high continuously.
  - Required: a new sweep begins exactly 2 cycles after each `done` edge, and the `count` latched for each sweep is the value present at that sweep's acceptance.
